// File: rtl/windowed_energy_sampler_pkg.sv
// Shared constants, the energy-width helper and the per-channel record
// types used by the windowed energy sampler.
package sampler_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DEPTH    = 64;
    localparam int DEF_CHANNELS = 2;

    // Width of a running energy: one full square plus log2(DEPTH) growth bits.
    function automatic int norm_width(input int width, input int depth);
        return 2 * width + $clog2(depth);
    endfunction

    localparam int DEF_NORM_W = 2 * DEF_WIDTH + $clog2(DEF_DEPTH);

    // Old/new sample pair for one channel at the default sample width.
    typedef struct packed {
        logic signed [DEF_WIDTH-1:0] old_sample;
        logic signed [DEF_WIDTH-1:0] new_sample;
    } sample_pair_t;

    // Running energy and threshold flag for one channel at the default widths.
    typedef struct packed {
        logic [DEF_NORM_W-1:0] norm;
        logic                  above;
    } energy_t;

endpackage

// File: rtl/windowed_energy_sampler_energy_accum.sv
// Per-channel energy pipeline: squares the entering and retiring samples,
// then folds their difference into the running sum of squares and compares
// the result against the shared threshold.
module energy_accum
    import sampler_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NORM_W = DEF_NORM_W
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    clear_in,
    input  logic                    v1_in,
    input  logic signed [WIDTH-1:0] old_in,
    input  logic signed [WIDTH-1:0] new_in,
    input  logic [NORM_W-1:0]       thresh_in,
    output logic [NORM_W-1:0]       norm_out,
    output logic                    above_out,
    output logic                    valid_out
);

    // A square of a WIDTH-bit signed value never exceeds 2^(2*WIDTH-2), so
    // 2*WIDTH-1 bits hold it exactly; multiplying at that width keeps the
    // arithmetic exact without a spare sign bit.
    localparam int SQ_W = 2 * WIDTH - 1;

    logic signed [SQ_W-1:0] old_ext;
    logic signed [SQ_W-1:0] new_ext;
    logic [SQ_W-1:0]        old_sq_c;
    logic [SQ_W-1:0]        new_sq_c;
    logic [SQ_W-1:0]        old_sq;
    logic [SQ_W-1:0]        new_sq;
    logic                   v2;
    logic [NORM_W-1:0]      norm_next;

    assign old_ext   = SQ_W'(old_in);
    assign new_ext   = SQ_W'(new_in);
    assign old_sq_c  = old_ext * old_ext;
    assign new_sq_c  = new_ext * new_ext;
    // The retired square was added when that sample entered, so this never wraps.
    assign norm_next = norm_out + NORM_W'(new_sq) - NORM_W'(old_sq);

    // S1: register both squares and carry the valid bit forward.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v2     <= 1'b0;
            old_sq <= '0;
            new_sq <= '0;
        end else if (clear_in) begin
            v2     <= 1'b0;
            old_sq <= '0;
            new_sq <= '0;
        end else begin
            v2 <= v1_in;
            if (v1_in) begin
                old_sq <= old_sq_c;
                new_sq <= new_sq_c;
            end
        end
    end

    // S2: update the running energy, its threshold flag and the update pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            norm_out  <= '0;
            above_out <= 1'b0;
            valid_out <= 1'b0;
        end else if (clear_in) begin
            norm_out  <= '0;
            above_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= v2;
            if (v2) begin
                norm_out  <= norm_next;
                above_out <= (norm_next > thresh_in);
            end
        end
    end

endmodule

// File: rtl/windowed_energy_sampler.sv
// Multi-channel sliding-window sample buffer with per-channel running energy,
// addressed read-back, window-full indication and threshold flags.
//
// Strobe semantics: ready_in is a one-cycle strobe with no back-pressure;
// every cycle with ready_in high and clear_in low accepts one sample per
// channel from signal_in. clear_in wins over ready_in in the same cycle.
// norm_valid_out pulses for exactly one cycle per accepted sample, two
// cycles after the accept, in accept order.
module windowed_energy_sampler
    import sampler_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int NORM_W   = norm_width(WIDTH, DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         ready_in,
    input  logic [CHANNELS*WIDTH-1:0]    signal_in,
    input  logic                         clear_in,
    input  logic [NORM_W-1:0]            thresh_in,
    input  logic [$clog2(DEPTH)-1:0]     rd_age_in,
    output logic [CHANNELS*WIDTH-1:0]    rd_data_out,
    output logic [$clog2(DEPTH)-1:0]     offset_out,
    output logic                         window_full_out,
    output logic [CHANNELS*NORM_W-1:0]   norm_out,
    output logic                         norm_valid_out,
    output logic [CHANNELS-1:0]          above_out
);

    localparam int AW = $clog2(DEPTH);

    logic signed [WIDTH-1:0]   mem [CHANNELS][DEPTH];
    logic [AW:0]               fill;
    logic                      v1;
    logic [CHANNELS*WIDTH-1:0] old_s1;
    logic [CHANNELS*WIDTH-1:0] new_s1;
    logic [AW-1:0]             rd_idx;
    logic                      accept;
    logic [CHANNELS-1:0]       valid_vec;

    assign accept = ready_in && !clear_in;
    // Age 0 is the slot just behind the write pointer; wraps mod DEPTH.
    assign rd_idx = offset_out - AW'(1) - rd_age_in;
    // fill saturates at DEPTH, a power of two, so its MSB is the full flag.
    assign window_full_out = fill[AW];
    // All channels share one valid pipeline, so their pulses always agree.
    assign norm_valid_out = &valid_vec;

    // Sample storage: flushed on reset/clear, one slot per channel written per accept.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int d = 0; d < DEPTH; d++)
                    mem[c][d] <= '0;
        end else if (clear_in) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int d = 0; d < DEPTH; d++)
                    mem[c][d] <= '0;
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++)
                mem[c][offset_out] <= signal_in[c*WIDTH +: WIDTH];
        end
    end

    // Write pointer, fill counter and stage-1 capture of the old/new sample pair.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            offset_out <= '0;
            fill       <= '0;
            v1         <= 1'b0;
            old_s1     <= '0;
            new_s1     <= '0;
        end else if (clear_in) begin
            offset_out <= '0;
            fill       <= '0;
            v1         <= 1'b0;
            old_s1     <= '0;
            new_s1     <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                offset_out <= offset_out + AW'(1);
                if (!fill[AW])
                    fill <= fill + (AW+1)'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    old_s1[c*WIDTH +: WIDTH] <= mem[c][offset_out];
                    new_s1[c*WIDTH +: WIDTH] <= signal_in[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Registered read-back; sees the contents before any same-cycle accept.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_out <= '0;
        end else if (clear_in) begin
            rd_data_out <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                rd_data_out[c*WIDTH +: WIDTH] <= mem[c][rd_idx];
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        energy_accum #(
            .WIDTH  (WIDTH),
            .NORM_W (NORM_W)
        ) u_accum (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .clear_in  (clear_in),
            .v1_in     (v1),
            .old_in    (old_s1[c*WIDTH +: WIDTH]),
            .new_in    (new_s1[c*WIDTH +: WIDTH]),
            .thresh_in (thresh_in),
            .norm_out  (norm_out[c*NORM_W +: NORM_W]),
            .above_out (above_out[c]),
            .valid_out (valid_vec[c])
        );
    end

endmodule

// File: tb/tb_windowed_energy_sampler.sv
// Bench for windowed_energy_sampler: directed steps with random side data,
// checked against a sum-of-squares reference over the last DEPTH samples.
module tb_windowed_energy_sampler;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 64;
    localparam int CHANNELS = 2;
    localparam int NORM_W   = 38;
    localparam int AW       = 6;
    localparam int W        = CHANNELS * NORM_W;

    logic                       clk_in;
    logic                       rst_n_in;
    logic                       ready_in;
    logic [CHANNELS*WIDTH-1:0]  signal_in;
    logic                       clear_in;
    logic [NORM_W-1:0]          thresh_in;
    logic [AW-1:0]              rd_age_in;
    logic [CHANNELS*WIDTH-1:0]  rd_data_out;
    logic [AW-1:0]              offset_out;
    logic                       window_full_out;
    logic [CHANNELS*NORM_W-1:0] norm_out;
    logic                       norm_valid_out;
    logic [CHANNELS-1:0]        above_out;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    int                hist [CHANNELS][$];
    logic [W-1:0]      exp_q[$];
    logic [NORM_W-1:0] thr_s2;

    windowed_energy_sampler #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .ready_in        (ready_in),
        .signal_in       (signal_in),
        .clear_in        (clear_in),
        .thresh_in       (thresh_in),
        .rd_age_in       (rd_age_in),
        .rd_data_out     (rd_data_out),
        .offset_out      (offset_out),
        .window_full_out (window_full_out),
        .norm_out        (norm_out),
        .norm_valid_out  (norm_valid_out),
        .above_out       (above_out)
    );

    // Clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present one cycle of inputs, return 1 time unit after the edge.
    task automatic step(input logic rdy, input logic clr, input int a, input int b);
        ready_in  = rdy;
        clear_in  = clr;
        signal_in = {16'(b), 16'(a)};
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    // Reference model: window of the last DEPTH accepted samples per channel,
    // energy is the plain sum of their squares.
    always @(posedge clk_in or negedge rst_n_in) begin : model
        logic [W-1:0] e;
        longint       s;
        if (!rst_n_in) begin
            for (int c = 0; c < CHANNELS; c++) hist[c].delete();
            exp_q.delete();
        end else begin
            thr_s2 = thresh_in;
            if (clear_in) begin
                for (int c = 0; c < CHANNELS; c++) hist[c].delete();
                exp_q.delete();
            end else if (ready_in) begin
                e = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    hist[c].push_back(int'($signed(signal_in[c*WIDTH +: WIDTH])));
                    if (hist[c].size() > DEPTH) void'(hist[c].pop_front());
                    s = 0;
                    foreach (hist[c][i]) s += longint'(hist[c][i]) * longint'(hist[c][i]);
                    e[c*NORM_W +: NORM_W] = s[NORM_W-1:0];
                end
                exp_q.push_back(e);
            end
        end
    end

    // Scoreboard: every update pulse must match the next expected energy.
    always @(negedge clk_in) begin : scoreboard
        logic [W-1:0]        e;
        logic [CHANNELS-1:0] exp_above;
        if (rst_n_in && norm_valid_out) begin
            pulses++;
            check("pulse_has_expectation", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("norm_out", norm_out, e);
                for (int c = 0; c < CHANNELS; c++)
                    exp_above[c] = (e[c*NORM_W +: NORM_W] > thr_s2);
                check("above_out", above_out, exp_above);
            end
        end
    end

    initial begin
        rst_n_in  = 1'b0;
        ready_in  = 1'b0;
        clear_in  = 1'b0;
        signal_in = '0;
        thresh_in = 38'd999;
        rd_age_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_norm", norm_out, '0);
        check("reset_above", above_out, '0);
        check("reset_offset", offset_out, '0);
        check("reset_full", window_full_out, 1'b0);
        check("reset_valid", norm_valid_out, 1'b0);
        check("reset_rd_data", rd_data_out, '0);
        rst_n_in = 1'b1;
        idle(2);

        // Fill: 64 accepts of 100 on channel 0, random on channel 1.
        for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 100, int'($urandom_range(0, 65535)));
        check("full_before_64th", window_full_out, 1'b0);
        step(1'b1, 1'b0, 100, int'($urandom_range(0, 65535)));
        check("full_after_64th", window_full_out, 1'b1);
        idle(4);
        check("norm_fill_100", norm_out[0 +: NORM_W], 38'd640000);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 100, int'($urandom_range(0, 65535)));
        idle(4);
        check("norm_steady_100", norm_out[0 +: NORM_W], 38'd640000);

        // Retirement: 64 zeros drain the window down to 0.
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 0, int'($urandom_range(0, 65535)));
        idle(4);
        check("norm_retired", norm_out[0 +: NORM_W], 38'd0);
        check("full_stays", window_full_out, 1'b1);

        // Extreme negative full-scale samples on both channels.
        step(1'b0, 1'b1, 0, 0);
        check("clear_offset", offset_out, '0);
        check("clear_full", window_full_out, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, -32768, -32768);
        idle(4);
        check("norm_extreme_ch0", norm_out[0 +: NORM_W], 38'h10_0000_0000);
        check("norm_extreme_ch1", norm_out[NORM_W +: NORM_W], 38'h10_0000_0000);

        // Read-back after accepting 1..70.
        step(1'b0, 1'b1, 0, 0);
        for (int i = 1; i <= 70; i++) step(1'b1, 1'b0, i, 1000 + i);
        check("offset_after_70", offset_out, 6'd6);
        rd_age_in = 6'd0;
        idle(1);
        check("rd_age0", rd_data_out, {16'd1070, 16'd70});
        rd_age_in = 6'd63;
        idle(1);
        check("rd_age63", rd_data_out, {16'd1007, 16'd7});
        rd_age_in = 6'd0;
        step(1'b1, 1'b0, 71, 1071);
        check("rd_pre_accept", rd_data_out, {16'd1070, 16'd70});
        idle(1);
        check("rd_post_accept", rd_data_out, {16'd1071, 16'd71});
        step(1'b0, 1'b1, 0, 0);
        rd_age_in = 6'd5;
        idle(1);
        check("rd_after_clear", rd_data_out, '0);
        idle(3);

        // Threshold: energies 900, 981, 990, 999, 1000 against 999.
        thresh_in = 38'd999;
        step(1'b1, 1'b0, 30, 0);
        step(1'b1, 1'b0, 9, 0);
        step(1'b1, 1'b0, 3, 0);
        step(1'b1, 1'b0, 3, 0);
        check("above_at_999", above_out[0], 1'b0);
        step(1'b1, 1'b0, 1, 0);
        idle(1);
        check("norm_999_step", norm_out[0 +: NORM_W], 38'd999);
        check("above_999_step", above_out[0], 1'b0);
        idle(1);
        check("norm_1000_step", norm_out[0 +: NORM_W], 38'd1000);
        check("above_1000_step", above_out[0], 1'b1);
        thresh_in = 38'd5000;
        idle(3);
        check("above_held", above_out[0], 1'b1);
        step(1'b1, 1'b0, 0, 0);
        idle(3);
        check("above_new_thresh", above_out[0], 1'b0);

        // Back-to-back random stream with a clear presented alongside ready.
        idle(2);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                step(1'b1, 1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
                check("offset_after_clear", offset_out, '0);
            end else begin
                step(1'b1, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            end
        end
        idle(5);
        check("pulse_count", pulses, 197);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
